// File: rtl/gnr_pkg.sv
// Shared types and defaults for the GNR attractor sequencer.
package gnr_pkg;

    localparam int unsigned N_NODES_DEF = 8;
    localparam int unsigned CNT_W_DEF   = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        CMP,
        PSTEP,
        PCMP,
        DONE
    } gnr_state_e;

endpackage

// File: rtl/gnr_step_cnt.sv
// Saturation-free step counter with synchronous clear and an equals-limit flag.
module gnr_step_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] cnt,
    output logic             at_limit_c
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign at_limit_c = (cnt == limit);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection sequencer for a two-copy GNR node network:
// finds the attractor, then measures its period with the tortoise frozen.
module gnr_attractor_ctrl
    import gnr_pkg::*;
#(
    parameter int unsigned N_NODES = N_NODES_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] seed,
    input  logic [CNT_W-1:0]   max_steps,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic               start_s0,
    output logic               start_s1,
    output logic [N_NODES-1:0] init_state,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               timeout,
    output logic [CNT_W-1:0]   steps_out,
    output logic [CNT_W-1:0]   period_out,
    output logic [N_NODES-1:0] attr_state
);

    gnr_state_e       state;
    logic [CNT_W-1:0] max_q;
    logic             start_acc_c;
    logic             step_lim_c;
    logic             per_lim_c;
    logic             same_c;

    assign start_acc_c = (state == IDLE) && start;
    assign same_c      = (s0_vec == s1_vec);

    gnr_step_cnt #(.CNT_W(CNT_W)) u_steps (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc_c),
        .en         (state == STEP),
        .limit      (max_q),
        .cnt        (steps_out),
        .at_limit_c (step_lim_c)
    );

    gnr_step_cnt #(.CNT_W(CNT_W)) u_period (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc_c),
        .en         (state == PSTEP),
        .limit      (max_q),
        .cnt        (period_out),
        .at_limit_c (per_lim_c)
    );

    // Strobes are raised on entry to their state so they last exactly that state's cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            max_q      <= '0;
            reset_nos  <= 1'b0;
            start_s0   <= 1'b0;
            start_s1   <= 1'b0;
            init_state <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            timeout    <= 1'b0;
            attr_state <= '0;
        end else begin
            reset_nos <= 1'b0;
            start_s0  <= 1'b0;
            start_s1  <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        init_state <= seed;
                        max_q      <= max_steps;
                        found      <= 1'b0;
                        timeout    <= 1'b0;
                        attr_state <= '0;
                        busy       <= 1'b1;
                        reset_nos  <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    if (max_q == '0) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        start_s0 <= 1'b1;
                        start_s1 <= 1'b1;
                        state    <= STEP;
                    end
                end
                STEP: state <= CMP;
                CMP: begin
                    // Tortoise and hare positions only line up on even step counts.
                    if (!steps_out[0] && same_c) begin
                        attr_state <= s1_vec;
                        start_s1   <= 1'b1;
                        state      <= PSTEP;
                    end else if (step_lim_c) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        start_s0 <= 1'b1;
                        start_s1 <= 1'b1;
                        state    <= STEP;
                    end
                end
                PSTEP: state <= PCMP;
                PCMP: begin
                    if (same_c) begin
                        found <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (per_lim_c) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        start_s1 <= 1'b1;
                        state    <= PSTEP;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Randomised bench for gnr_attractor_ctrl with a behavioural node network
// and a sequence-level Floyd reference model.
module tb_gnr_attractor_ctrl;

    localparam int unsigned N = 8;
    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] seed = '0;
    logic [W-1:0] max_steps = '0;
    logic [N-1:0] s0_vec, s1_vec;
    logic         reset_nos, start_s0, start_s1;
    logic [N-1:0] init_state, attr_state;
    logic         busy, done, found, timeout;
    logic [W-1:0] steps_out, period_out;

    int n_tests = 0;
    int n_fail  = 0;

    gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .max_steps  (max_steps),
        .s0_vec     (s0_vec),
        .s1_vec     (s1_vec),
        .reset_nos  (reset_nos),
        .start_s0   (start_s0),
        .start_s1   (start_s1),
        .init_state (init_state),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .timeout    (timeout),
        .steps_out  (steps_out),
        .period_out (period_out),
        .attr_state (attr_state)
    );

    always #5 clk = ~clk;

    // Network: 0 identity, 1 inverter, 2 low-3-bit incrementer, 3 random map.
    int           mode = 0;
    logic [N-1:0] lut [256];

    function automatic logic [N-1:0] net_f(input logic [N-1:0] x);
        case (mode)
            0:       return x;
            1:       return ~x;
            2:       return {x[7:3], x[2:0] + 3'd1};
            default: return lut[x];
        endcase
    endfunction

    logic [N-1:0] net_s0 = '0;
    logic [N-1:0] net_s1 = '0;
    logic         s0_ph  = 1'b0;

    always @(posedge clk) begin
        if (reset_nos) begin
            net_s0 <= init_state;
            net_s1 <= init_state;
            s0_ph  <= 1'b0;
        end else begin
            if (start_s1) net_s1 <= net_f(net_s1);
            if (start_s0) begin
                s0_ph <= ~s0_ph;
                if (s0_ph) net_s0 <= net_f(net_s0);
            end
        end
    end

    assign s0_vec = net_s0;
    assign s1_vec = net_s1;

    // Cumulative strobe and rule-violation counters; runs take deltas.
    int n_rn = 0, n_s0 = 0, n_s1 = 0, n_viol = 0;
    always @(negedge clk) begin
        if (reset_nos) n_rn <= n_rn + 1;
        if (start_s0)  n_s0 <= n_s0 + 1;
        if (start_s1)  n_s1 <= n_s1 + 1;
        if ((start_s0 && !start_s1) || (reset_nos && (start_s0 || start_s1)) || (found && timeout))
            n_viol <= n_viol + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sequence-level reference: hare at f^k(seed), tortoise at f^(k/2)(seed).
    task automatic ref_run(input logic [N-1:0] sd, input int mx,
                           output bit e_found, output bit e_to, output int e_steps,
                           output int e_per, output logic [N-1:0] e_attr);
        logic [N-1:0] tort, hare, x;
        bit hit = 0;
        e_found = 0; e_to = 0; e_steps = 0; e_per = 0; e_attr = '0;
        tort = sd; hare = sd;
        if (mx == 0) begin
            e_to = 1;
            return;
        end
        for (int k = 1; k <= mx; k++) begin
            hare = net_f(hare);
            if (k % 2 == 0) tort = net_f(tort);
            e_steps = k;
            if (k % 2 == 0 && hare == tort) begin
                hit = 1;
                break;
            end
        end
        if (!hit) begin
            e_to = 1;
            return;
        end
        e_attr = hare;
        x = hare;
        for (int p = 1; p <= mx; p++) begin
            x = net_f(x);
            e_per = p;
            if (x == tort) begin
                e_found = 1;
                return;
            end
        end
        e_to = 1;
    endtask

    task automatic run_case(input string tag, input int md, input logic [N-1:0] sd,
                            input int mx, input bit extra_start);
        bit got = 0;
        bit e_found, e_to;
        int e_steps, e_per, budget;
        int rn0, s00, s10, v0;
        logic [N-1:0] e_attr;
        mode = md;
        ref_run(sd, mx, e_found, e_to, e_steps, e_per, e_attr);
        budget = 4 * mx + 64;
        @(negedge clk);
        rn0 = n_rn; s00 = n_s0; s10 = n_s1; v0 = n_viol;
        seed = sd; max_steps = W'(mx); start = 1'b1;
        @(negedge clk);
        start = 1'b0; seed = N'($urandom); max_steps = W'($urandom);
        check_eq({tag, ".busy_on"}, 32'(busy), 32'd1);
        for (int c = 0; c < budget && !got; c++) begin
            start = extra_start && (c == 1);
            if (start) seed = ~sd;
            @(negedge clk);
            if (done) got = 1;
        end
        start = 1'b0;
        check_eq({tag, ".done_seen"}, 32'(got), 32'd1);
        check_eq({tag, ".found"}, 32'(found), 32'(e_found));
        check_eq({tag, ".timeout"}, 32'(timeout), 32'(e_to));
        check_eq({tag, ".steps"}, 32'(steps_out), 32'(e_steps));
        check_eq({tag, ".period"}, 32'(period_out), 32'(e_per));
        check_eq({tag, ".attr"}, 32'(attr_state), 32'(e_attr));
        check_eq({tag, ".busy_off"}, 32'(busy), 32'd0);
        @(negedge clk);
        check_eq({tag, ".done_1cyc"}, 32'(done), 32'd0);
        check_eq({tag, ".found_hold"}, 32'(found), 32'(e_found));
        check_eq({tag, ".reset_nos_cnt"}, 32'(n_rn - rn0), 32'd1);
        check_eq({tag, ".rules"}, 32'(n_viol - v0), 32'd0);
        if (mx == 0) begin
            check_eq({tag, ".no_s0"}, 32'(n_s0 - s00), 32'd0);
            check_eq({tag, ".no_s1"}, 32'(n_s1 - s10), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".done"}, 32'(done), 32'd0);
        check_eq({tag, ".flags"}, 32'({found, timeout}), 32'd0);
        check_eq({tag, ".strobes"}, 32'({reset_nos, start_s0, start_s1}), 32'd0);
        check_eq({tag, ".steps"}, 32'(steps_out), 32'd0);
        check_eq({tag, ".period"}, 32'(period_out), 32'd0);
        check_eq({tag, ".attr"}, 32'(attr_state), 32'd0);
        check_eq({tag, ".init"}, 32'(init_state), 32'd0);
    endtask

    initial begin
        bit seen = 0;
        for (int i = 0; i < 256; i++) lut[i] = N'($urandom);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        run_case("ident", 0, 8'h01, 20, 0);
        run_case("inv", 1, 8'h00, 20, 0);
        run_case("inc40", 2, 8'h00, 40, 0);
        run_case("inc10", 2, 8'h00, 10, 0);
        run_case("max0", 2, 8'h00, 0, 0);
        run_case("busy_start", 2, 8'h00, 40, 1);

        // Reset during the period phase, then a clean rerun.
        mode = 2;
        @(negedge clk);
        seed = 8'h00; max_steps = W'(40); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (start_s1 && !start_s0) seen = 1;
        end
        check_eq("rst_mid.pstep_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rst_mid");
        run_case("after_rst", 2, 8'h00, 40, 0);

        for (int r = 0; r < 30; r++) begin
            int md = (r % 3 == 0) ? 2 : 3;
            int mx = (r % 5 == 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 80));
            run_case($sformatf("rand%0d", r), md, N'($urandom), mx, r % 7 == 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
